// File: rtl/shift_sequencer.sv
// Multi-mode shift/rotate sequencer with start/busy/done handshake.
// Define SHIFT_SEQUENCER_BARREL_EN to finish any k-position move in one RUN edge.
module shift_sequencer #(
  parameter int N  = 8,
  parameter int AW = $clog2(N + 1)
) (
  input  logic          c,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  d,
  input  logic          i,
  output logic [N-1:0]  q,
  output logic          so,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  localparam logic [AW-1:0] N_AMT = AW'(N);

  state_t        state_reg, state_next;
  logic [N-1:0]  q_reg, q_next;
  logic          so_reg, so_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [2:0]    op_reg, op_next;

  logic [AW-1:0] amt_eff;
  logic          is_move;
  logic [N-1:0]  move_q;
  logic          move_so;

  assign amt_eff = (amt > N_AMT) ? N_AMT : amt;

  always_comb begin
    is_move = 1'b0;
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: is_move = 1'b1;
      default:                                is_move = 1'b0;
    endcase
  end

`ifdef SHIFT_SEQUENCER_BARREL_EN
  // Left and right moves share one wide shifter each; the extra guard bit
  // on the outgoing side captures the last bit that left q.
  logic [N-1:0] left_fill, right_fill;
  logic [2*N:0] wide_left, wide_right;
  logic         unused_bits;

  always_comb begin
    left_fill  = (op_reg == OP_ROL) ? q_reg : {N{i}};
    right_fill = {N{i}};
    if (op_reg == OP_ROR)
      right_fill = q_reg;
    else if (op_reg == OP_ASR)
      right_fill = {N{q_reg[N-1]}};
    wide_left  = {1'b0, q_reg, left_fill} << cnt_reg;
    wide_right = {right_fill, q_reg, 1'b0} >> cnt_reg;
    if (op_reg == OP_SHL || op_reg == OP_ROL) begin
      move_q  = wide_left[2*N-1:N];
      move_so = wide_left[2*N];
    end else begin
      move_q  = wide_right[N:1];
      move_so = wide_right[0];
    end
  end

  assign unused_bits = ^{wide_left[N-1:0], wide_right[2*N:N+1]};
`else
  always_comb begin
    move_q  = q_reg;
    move_so = so_reg;
    case (op_reg)
      OP_SHL: begin move_q = {q_reg[N-2:0], i};          move_so = q_reg[N-1]; end
      OP_SHR: begin move_q = {i, q_reg[N-1:1]};          move_so = q_reg[0];   end
      OP_ROL: begin move_q = {q_reg[N-2:0], q_reg[N-1]}; move_so = q_reg[N-1]; end
      OP_ROR: begin move_q = {q_reg[0], q_reg[N-1:1]};   move_so = q_reg[0];   end
      OP_ASR: begin move_q = {q_reg[N-1], q_reg[N-1:1]}; move_so = q_reg[0];   end
      default: begin move_q = q_reg;                     move_so = so_reg;     end
    endcase
  end
`endif

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    so_next    = so_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          op_next = op;
          if (op == OP_LOAD) begin
            q_next     = d;
            state_next = DONE;
          end else if (is_move && amt_eff != '0) begin
            cnt_next   = amt_eff;
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        q_next  = move_q;
        so_next = move_so;
`ifdef SHIFT_SEQUENCER_BARREL_EN
        cnt_next   = '0;
        state_next = DONE;
`else
        cnt_next = cnt_reg - AW'(1);
        if (cnt_reg == AW'(1))
          state_next = DONE;
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      so_reg    <= 1'b0;
      cnt_reg   <= '0;
      op_reg    <= OP_HOLD;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      so_reg    <= so_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
    end
  end

  assign q    = q_reg;
  assign so   = so_reg;
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Parametrised, multi-mode shift register with a command handshake. It loads, holds, shifts (logical or arithmetic), or rotates an N-bit word by a requested amount. By default it moves one position per clock and streams the serial input in and the serial output out. It is the general-purpose successor to the fixed 4-mode universal shift register and is intended for serial links, bit-serial arithmetic and test-pattern generators.

## Interface
- N, 8, register width (N >= 2)
- AW, $clog2(N+1), width of the shift-amount field
- c  input  1  clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  command strobe; accepted only while idle
- op  input  3  command: 000 hold, 001 load, 010 SHL, 011 SHR (logical), 100 ROL, 101 ROR, 110 ASR, 111 reserved (treated as hold)
- amt  input  AW  shift or rotate distance in positions
- d  input  N  parallel load data
- i  input  1  serial fill bit for SHL/SHR
- q  output  N  register contents
- so  output  1  most recent bit shifted or rotated out of q
- busy  output  1  high whenever a command is in progress (states RUN and DONE)
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE. busy = (state != IDLE). done = (state == DONE).
- In IDLE with start=1 at edge E0, op and the effective amount are latched. The effective amount is k = min(amt, N).
  - load: q <= d at E0; next state DONE.
  - hold, reserved, or any shift/rotate with k=0: q unchanged; next state DONE.
  - shift/rotate with k>0: counter <= k; next state RUN.
- In RUN, each edge moves q by one position and decrements the counter. When the counter goes 1->0, the next state is DONE.
  - SHL: q <= {q[N-2:0], i}; so <= q[N-1].
  - SHR: q <= {i, q[N-1:1]}; so <= q[0].
  - ROL: q <= {q[N-2:0], q[N-1]}; so <= q[N-1].
  - ROR: q <= {q[0], q[N-1:1]}; so <= q[0].
  - ASR: q <= {q[N-1], q[N-1:1]}; so <= q[0].
- i is sampled live on every RUN edge, so a changing i streams a different bit into each position.
- DONE lasts exactly one cycle, then the block returns to IDLE.
- start is ignored in RUN and DONE, and is not queued. A start asserted during the DONE cycle is dropped.
- d, op and amt are don't-care except at the accepting edge.
- so changes only on RUN edges (or on the single barrel edge, see Configuration). It holds its value through load and hold commands.

## Timing
- Reset values: q=0, so=0, busy=0, done=0, state IDLE, counter=0.
- Reset asserted mid-command aborts the command immediately, with no done pulse. The first start is accepted at the first rising edge after rst deasserts.
- Latency for a shift/rotate of k positions: q changes at edges E1..Ek. done is high between Ek and Ek+1. busy is high from E0 to Ek+1. The next start can be accepted at Ek+1.
- Latency for load, hold, or k=0: done is high between E0 and E1. busy is high for that same single cycle.
- Any amt > N is clamped to N. Consequently, ROL/ROR by N returns the original q, and SHL/SHR by N replaces all of q with fill bits.

## Configuration
- SHIFT_SEQUENCER_BARREL_EN defined:
  - A shift/rotate with k>0 completes in a single RUN edge (E1): q becomes the full k-position result.
  - SHL/SHR fill all k vacated bits with i as sampled at E1.
  - so is the last bit that would have left q, i.e. original q[N-k] for SHL/ROL and q[k-1] for SHR/ROR/ASR.
  - done is high between E1 and E2, regardless of k.
- Macro undefined: the one-position-per-cycle behaviour described above. The counter and serial streaming semantics apply.

## Test plan
- Reset then load: rst pulse; start, op=001, d=8'hA5 -> q=8'hA5 after E0, done=1 for exactly one cycle, so=0.
- Serial SHL stream: q=8'h00; start, op=010, amt=4; i=1,0,1,1 on E1..E4 -> q=8'h0B, done high after E4, busy high for 5 cycles.
- Rotate and clamp: q=8'h81; ROR amt=1 -> q=8'hC0, so=1. Then ROL amt=15 (clamped to 8) -> q=8'hC0, done after 8 cycles.
- ASR sign fill: q=8'h90; ASR amt=3 -> q=8'hF2, so=0. Start pulses during RUN -> ignored, q unaffected.
- Reset mid-operation: SHR amt=8 on q=8'hFF; rst asserted after E3 -> q=0, busy=0, no done pulse. New load accepted after release.
- Barrel build (macro defined): q=8'h3C, SHL amt=2, i=1 -> q=8'hF3 at E1, so=0, done between E1 and E2.
